// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage PC sequencer with multi-cycle imem handshake.
// Optional perf counters under `define FETCH_PERF_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PC_LO      = 32'h0000_3000,
  parameter logic [31:0] PC_HI      = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        adel_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] discard_cnt_o
);

  typedef enum logic [1:0] {S_FETCH, S_DISCARD, S_VALID} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] disc_addr_q, disc_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        adel_q, adel_d;

  logic        eret_acc, br_acc, redirect;
  logic [31:0] redirect_pc, seq_pc;
  logic        pc_legal, req_c, consume, drop;
  logic [31:0] addr_c;

  assign eret_acc    = eret_i & ~stall_i & ~exc_req_i;
  assign br_acc      = br_valid_i & ~stall_i & ~exc_req_i & ~eret_i;
  assign redirect    = exc_req_i | eret_acc;
  assign redirect_pc = exc_req_i ? HANDLER_PC : epc_i;
  // A branch resolved in the same cycle as the delay-slot ack bypasses the pending buffer.
  assign seq_pc      = br_acc ? br_target_i : (pend_valid_q ? pend_target_q : pc_q + 32'd4);
  assign pc_legal    = (pc_q[1:0] == 2'b00) && (pc_q >= PC_LO) && (pc_q <= PC_HI);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    disc_addr_d   = disc_addr_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    valid_d       = valid_q;
    adel_d        = adel_q;
    req_c         = 1'b0;
    addr_c        = pc_q;
    consume       = 1'b0;
    drop          = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d         = redirect_pc;
          pend_valid_d = 1'b0;
        end
        if (pc_legal) begin
          req_c = 1'b1;
          if (redirect) begin
            if (imem_ack_i) begin
              drop = 1'b1;
            end else begin
              disc_addr_d = pc_q;
              state_d     = S_DISCARD;
            end
          end else if (imem_ack_i) begin
            instr_d      = imem_rdata_i;
            pc_out_d     = pc_q;
            valid_d      = 1'b1;
            adel_d       = 1'b0;
            pc_d         = seq_pc;
            pend_valid_d = 1'b0;
            state_d      = S_VALID;
          end else if (br_acc) begin
            pend_valid_d  = 1'b1;
            pend_target_d = br_target_i;
          end
        end else if (!redirect) begin
          instr_d      = 32'd0;
          pc_out_d     = pc_q;
          valid_d      = 1'b1;
          adel_d       = 1'b1;
          pc_d         = seq_pc;
          pend_valid_d = 1'b0;
          state_d      = S_VALID;
        end
      end
      S_DISCARD: begin
        // Bus request stays on the abandoned address until the slave completes it.
        req_c  = 1'b1;
        addr_c = disc_addr_q;
        if (redirect) begin
          pc_d         = redirect_pc;
          pend_valid_d = 1'b0;
        end
        if (imem_ack_i) begin
          drop    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_VALID: begin
        if (redirect) begin
          valid_d      = 1'b0;
          pc_d         = redirect_pc;
          pend_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else if (!stall_i) begin
          valid_d = 1'b0;
          consume = 1'b1;
          state_d = S_FETCH;
          if (br_acc) pc_d = br_target_i;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'd0;
      pend_valid_q  <= 1'b0;
      disc_addr_q   <= 32'd0;
      instr_q       <= 32'd0;
      pc_out_q      <= RESET_PC;
      valid_q       <= 1'b0;
      adel_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
      disc_addr_q   <= disc_addr_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      valid_q       <= valid_d;
      adel_q        <= adel_d;
    end
  end

  assign imem_req_o    = req_c & ~reset;
  assign imem_addr_o   = addr_c;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_out_q;
  assign adel_o        = adel_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, discard_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q   <= 32'd0;
      discard_cnt_q <= 32'd0;
    end else begin
      if (consume) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (drop) discard_cnt_q <= discard_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o   = fetch_cnt_q;
  assign discard_cnt_o = discard_cnt_q;
`else
  logic perf_unused;
  assign perf_unused   = consume | drop;
  assign fetch_cnt_o   = 32'd0;
  assign discard_cnt_o = 32'd0;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the fetch-stage PC and a multi-cycle instruction-memory handshake for the five-stage MIPS pipeline.
- Arbitrates the next-PC sources in this priority order: CP0 exception/interrupt, eret, D-stage branch/jump, sequential PC+4.
- Buffers a branch target that is resolved while the delay-slot fetch is still in flight.
- Flushes in-flight fetches on exception or eret, and presents one fetched instruction at a time to the F/D register.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
HANDLER_PC, 32'h0000_4180, exception entry PC
PC_LO, 32'h0000_3000, lowest legal fetch address
PC_HI, 32'h0000_6ffc, highest legal fetch address

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall_i  in  1  D-stage stall from hazard unit
br_valid_i  in  1  D-stage branch/jump taken
br_target_i  in  32  branch/jump target
exc_req_i  in  1  CP0 exception/interrupt request
eret_i  in  1  eret in D
epc_i  in  32  EPC from CP0
imem_req_o  out  1  instruction bus request
imem_addr_o  out  32  instruction bus address
imem_ack_i  in  1  bus ack; data valid in the same cycle
imem_rdata_i  in  32  fetched word
instr_valid_o  out  1  instruction presented to F/D
instr_o  out  32  presented instruction
pc_o  out  32  PC of presented instruction
adel_o  out  1  presented instruction has a fetch address error

Behaviour:
- Reset: state=FETCH, pc=RESET_PC, pend_valid=0, instr_valid_o=0, instr_o=0, pc_o=RESET_PC, adel_o=0.
- imem_req_o=0 while reset is high.
- Acceptance rules:
  - exc_req_i is always accepted.
  - eret_i and br_valid_i are accepted only when stall_i=0.
  - If more than one is accepted in the same cycle, exc wins over eret, and eret wins over br.
- Legal address: pc[1:0]==0 and PC_LO<=pc<=PC_HI.
- FETCH state:
  - Legal pc: imem_req_o=1, imem_addr_o=pc.
  - On ack: instr_o<=rdata, pc_o<=pc, instr_valid_o<=1, adel_o<=0, go to VALID.
  - Next pc on ack: pend_target if pend_valid, else pc+4; clear pend_valid.
  - Illegal pc: no request is issued. Next cycle presents instr_o=0, adel_o=1, pc_o=pc; pc<=pc+4; go to VALID.
- Branch accepted in FETCH (current fetch is the delay slot):
  - pend_valid<=1, pend_target<=br_target_i.
  - If the ack arrives in the same cycle, pc<=br_target_i directly.
- exc/eret accepted in FETCH:
  - pc<=HANDLER_PC or epc_i; clear pend_valid.
  - If no ack this cycle, go to DISCARD.
  - If ack this cycle, drop the data and stay in FETCH.
- DISCARD state:
  - imem_req_o stays 1 and imem_addr_o stays on the old address; req and addr are stable until ack.
  - On ack: drop the data, go to FETCH.
  - A further exc accepted here updates pc and stays in DISCARD.
- VALID state:
  - Outputs are held while stall_i=1.
  - With stall_i=0 the instruction is consumed at the edge: instr_valid_o<=0, go to FETCH.
  - Branch accepted: pc<=br_target_i; the held instruction is the delay slot and is kept.
  - exc/eret: instr_valid_o<=0, pc<=HANDLER_PC/epc_i, go to FETCH; this applies even when stall_i=1 for exc.
- pc+4 wraps modulo 2^32; a wrapped pc is illegal and raises adel_o.
- A second branch while pend_valid=1 cannot occur; if it does, the newer target overwrites the pending one.
- Reset mid-transaction: req is dropped immediately, and a late ack is ignored because state=FETCH and req=0.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: two 32-bit wrapping counters, fetch_cnt_o and discard_cnt_o, both cleared on reset.
  - fetch_cnt_o increments on every instruction consumed.
  - discard_cnt_o increments on every ack whose data is dropped.
- Undefined: the ports exist and are tied to 0; no counter registers are generated.

Test Plan:
- Reset, then ack every cycle, stall_i=0 -> imem_addr_o sequence 3000, 3004, 3008; pc_o on valid matches; adel_o=0.
- Ack delayed 3 cycles on 3004, with br_valid_i/target 3100 asserted in cycle 1 -> instruction 3004 presented, next imem_addr_o=3100.
- exc_req_i while fetch of 3008 is outstanding, ack 2 cycles later -> that data is dropped, next request to 4180, instr_valid_o never shows 3008.
- VALID at 3010 with stall_i=1 for 4 cycles -> outputs stable; eret_i with epc 3200 ignored until stall_i=0, then next fetch at 3200 and 3010 is not consumed.
- br_target_i=3002 -> no bus request; instr_valid_o=1, instr_o=0, adel_o=1, pc_o=3002; then exc_req_i -> fetch at 4180.
- Reset asserted while req is pending, ack arrives during reset -> instr_valid_o=0, first post-reset address 3000.
